// File: rtl/instr_encoder_loader_if.sv
// ============================================================================
// Module  : instr_encoder_loader_if
// Brief   : Symbolic-instruction input, memory-write and session-control bundle
//           for instr_encoder_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_encoder_loader_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       count;

    modport master (
        output start, base_addr, in_valid, in_kind, in_rs, in_rt, in_rd,
               in_imm, in_target, in_last, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, base_addr, in_valid, in_kind, in_rs, in_rt, in_rd,
               in_imm, in_target, in_last, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module  : instr_encoder_loader
// Brief   : Encodes symbolic instructions, queues them and writes them into
//           instruction memory at consecutive word addresses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_encoder_loader #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instr_encoder_loader_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [31:0]       r_fifo [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_occ;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_count;
    logic              r_err;

    logic        w_full, w_empty, w_accept, w_push, w_pop, w_start_ok;
    logic        w_legal, w_in_ready, w_busy, w_done;
    logic [31:0] w_word;

    assign w_full     = (r_occ == C_FULL);
    assign w_empty    = (r_occ == '0);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_push     = w_accept && w_legal;
    assign w_pop      = !w_empty && bus.mem_ready;
    assign w_start_ok = (r_state == S_IDLE) && bus.start;

    // Same opcode/func map the control decoder uses; unused fields stay zero.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (bus.in_kind)
            4'd0:    w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b000001};
            4'd1:    w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b000010};
            4'd2:    w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b000100};
            4'd3:    w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b001000};
            4'd4:    w_word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'b010000};
            4'd5:    w_word = {6'b000001, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6:    w_word = {6'b000010, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7:    w_word = {6'b000011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8:    w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:    w_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd10:   w_word = {6'b000110, bus.in_target};
            4'd11:   w_word = {6'b000111, bus.in_rs, 21'd0};
            4'd12:   w_word = {6'b001000, bus.in_target};
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && bus.in_last) w_next = S_DRAIN;
            S_DRAIN: if (w_empty) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // No bypass: a full FIFO refuses input even in a cycle where it pops.
    always_comb begin
        w_in_ready = (r_state == S_LOAD) && !w_full;
        w_busy     = (r_state != S_IDLE);
        w_done     = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_word;
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase

            if (w_start_ok)  r_addr <= bus.base_addr;
            else if (w_pop)  r_addr <= r_addr + ADDR_W'(4);

            if (w_start_ok)                          r_count <= '0;
            else if (w_pop && r_count != 16'hFFFF)   r_count <= r_count + 16'd1;

            if (w_start_ok)                r_err <= 1'b0;
            else if (w_accept && !w_legal) r_err <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.count     = r_count;
    assign bus.mem_we    = !w_empty;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = w_empty ? 32'd0 : r_fifo[r_rptr];

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module  : tb_instr_encoder_loader
// Brief   : Scoreboard bench for instr_encoder_loader.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;
    logic [31:0] exp_addr;
    logic [63:0] sb_q[$];

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] w;
        if (k < 4'd5)       w = {6'd0, rs, rt, rd, 5'd0, 6'(1 << k)};
        else if (k < 4'd10) w = {6'(k - 4'd4), rs, rt, imm};
        else if (k == 4'd10) w = {6'd6, tgt};
        else if (k == 4'd11) w = {6'd7, rs, 21'd0};
        else if (k == 4'd12) w = {6'd8, tgt};
        else                 w = 32'd0;
        return w;
    endfunction

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (rst_n && bus.mem_we && bus.mem_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {bus.mem_addr, bus.mem_wdata}, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("write_addr", 64'(bus.mem_addr), 64'(e[63:32]));
                check("write_data", 64'(bus.mem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic start_session(input logic [31:0] base);
        bus.start = 1'b1;
        bus.base_addr = base;
        @(posedge clk); #1;
        bus.start = 1'b0;
        exp_addr = base;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        check("err_cleared", 64'(bus.err), 64'd0);
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        bit got;
        got = 1'b0;
        bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_imm = imm; bus.in_target = tgt; bus.in_last = last; bus.in_valid = 1'b1;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1'b1;
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
        else if (k <= 4'd12) begin
            sb_q.push_back({exp_addr, enc(k, rs, rt, rd, imm, tgt)});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("count", 64'(bus.count), 64'(exp_count));
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("idle_after_done", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        int k;
        int d0;
        logic [63:0] snap;
        n_cmp = 0; n_bad = 0; done_cnt = 0; exp_addr = '0;
        rst_n = 1'b0;
        bus.start = 0; bus.base_addr = '0; bus.in_valid = 0; bus.in_kind = '0;
        bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0; bus.in_imm = '0;
        bus.in_target = '0; bus.in_last = 0; bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_status", {bus.in_ready, bus.busy, bus.done, bus.err}, 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single ADD
        start_session(32'h100);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        wait_done(1);

        // 2: LW, J, JAL, JR
        start_session(32'h200);
        send(4'd7, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 1'b0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h40, 1'b0);
        send(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        send(4'd11, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        check("lw_encoding_model", 64'(enc(4'd7, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0)), 64'h0C850010);
        wait_done(4);

        // 3: back-pressure fills the FIFO
        bus.mem_ready = 1'b0;
        start_session(32'h300);
        acc = 0; k = 0;
        bus.in_kind = 4'd1; bus.in_rs = 5'd1; bus.in_rt = 5'd2; bus.in_rd = 5'd3;
        bus.in_imm = '0; bus.in_target = '0; bus.in_last = 1'b0; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back({exp_addr, enc(4'd1, 5'(k + 1), 5'(k + 2), 5'(k + 3), 16'h0, 26'h0)});
                exp_addr = exp_addr + 32'd4;
                acc++; k++;
            end
            @(posedge clk); #1;
            bus.in_rs = 5'(k + 1); bus.in_rt = 5'(k + 2); bus.in_rd = 5'(k + 3);
        end
        bus.in_valid = 1'b0;
        check("full_accepts", 64'(acc), 64'(DEPTH));
        @(negedge clk);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_mem_we", 64'(bus.mem_we), 64'd1);
        snap = {bus.mem_addr, bus.mem_wdata};
        repeat (3) @(negedge clk);
        check("stall_stable", {bus.mem_addr, bus.mem_wdata}, snap);
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        send(4'd5, 5'd6, 5'd7, 5'd0, 16'hBEEF, 26'h0, 1'b1);
        wait_done(DEPTH + 1);

        // 4: illegal kind between two ADDs
        start_session(32'h400);
        send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        send(4'd14, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        check("err_set", 64'(bus.err), 64'd1);
        @(posedge clk); #1;
        send(4'd0, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 1'b1);
        wait_done(2);
        check("err_sticky", 64'(bus.err), 64'd1);

        // 5: address wrap
        start_session(32'hFFFF_FFFC);
        send(4'd2, 5'd8, 5'd9, 5'd10, 16'h0, 26'h0, 1'b0);
        send(4'd9, 5'd11, 5'd12, 5'd0, 16'hFFFE, 26'h0, 1'b1);
        wait_done(2);

        // 6: reset mid-drain
        bus.mem_ready = 1'b0;
        start_session(32'h500);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        send(4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        send(4'd6, 5'd7, 5'd8, 5'd0, 16'h1234, 26'h0, 1'b1);
        @(negedge clk);
        check("drain_queued", {bus.busy, bus.mem_we}, 64'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_mem_we", 64'(bus.mem_we), 64'd0);
        check("abort_addr_data", {bus.mem_addr, bus.mem_wdata}, 64'd0);
        check("abort_status", {bus.busy, bus.count, bus.in_ready}, 64'd0);
        sb_q.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        start_session(32'h600);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        wait_done(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
